cp0_exc_ctrl: RTL and testbench

- Coprocessor-0 exception and interrupt controller, placed at the MEM stage.
- Consumes the exception code, PC and branch-delay flag carried by the EX/MEM pipeline register, plus the six external hardware interrupt lines.
- Holds SR, Cause, EPC and PRId; decides when the pipeline must be flushed and redirected to the handler.
- Drives the int_clr input of every pipeline register and the PC-select logic; serves mfc0/mtc0 and eret.

---
 rtl/cp0_exc_ctrl_pkg.sv | 46 ++++
 rtl/cp0_exc_ctrl_if.sv | 29 ++
 rtl/cp0_exc_ctrl.sv | 81 ++++++++
 tb/tb_cp0_exc_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// CP0 exception controller shared definitions: register numbers,
// field positions, exception codes and entry address.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_BD    = 31;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] PRID_DEF       = 32'h0000_4D4D;

    function automatic logic [31:0] sr_word(
        input logic [5:0] im, input logic exl, input logic ie);
        logic [31:0] w;
        w = '0;
        w[SR_IM_LO +: 6] = im;
        w[SR_EXL] = exl;
        w[SR_IE] = ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_word(
        input logic bd, input logic [5:0] ip, input logic [4:0] code);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD] = bd;
        w[CAUSE_IP_LO +: 6] = ip;
        w[CAUSE_EXC_LO +: 5] = code;
        return w;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// MEM-stage <-> CP0 bundle: exception inputs, mfc0/mtc0/eret traffic
// and the flush/redirect outputs.
interface cp0_exc_ctrl_if;
    logic [31:0] pc_M;
    logic [4:0]  exc_code_M;
    logic        bd_M;
    logic [5:0]  hwint;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        eret_M;
    logic [31:0] rd_data;
    logic [31:0] epc;
    logic        exc_req;
    logic [31:0] handler_pc;

    modport master (
        output pc_M, exc_code_M, bd_M, hwint, rd_addr,
        output wr_addr, wr_en, wr_data, eret_M,
        input  rd_data, epc, exc_req, handler_pc
    );

    modport slave (
        input  pc_M, exc_code_M, bd_M, hwint, rd_addr,
        input  wr_addr, wr_en, wr_data, eret_M,
        output rd_data, epc, exc_req, handler_pc
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller at the MEM stage:
// holds SR/Cause/EPC/PRId and raises the pipeline flush request.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] PRID       = PRID_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input logic         clk,
    input logic         reset,
    cp0_exc_ctrl_if.slave bus
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc_q;

    logic        int_hit;
    logic        exc_hit;
    logic        req;
    logic [31:0] victim_pc;

    // Interrupts look at the live lines so a request is taken the same cycle.
    assign int_hit = ie & ~exl & (|(im & bus.hwint));
    assign exc_hit = ~exl & (bus.exc_code_M != EXC_INT);
    assign req     = int_hit | exc_hit;

    assign victim_pc = bus.bd_M ? bus.pc_M - 32'd4 : bus.pc_M;

    assign bus.exc_req    = req;
    assign bus.epc        = epc_q;
    assign bus.handler_pc = HANDLER_PC;

    always_comb begin
        bus.rd_data = '0;
        case (bus.rd_addr)
            CP0_SR:    bus.rd_data = sr_word(im, exl, ie);
            CP0_CAUSE: bus.rd_data = cause_word(bd, ip, exc_code);
            CP0_EPC:   bus.rd_data = epc_q;
            CP0_PRID:  bus.rd_data = PRID;
            default:   bus.rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc_q    <= '0;
        end else begin
            ip <= bus.hwint;
            if (req) begin
                exl      <= 1'b1;
                bd       <= bus.bd_M;
                epc_q    <= victim_pc & ~32'd3;
                exc_code <= int_hit ? EXC_INT : bus.exc_code_M;
            end else if (bus.eret_M) begin
                exl <= 1'b0;
            end else if (bus.wr_en) begin
                case (bus.wr_addr)
                    CP0_SR: begin
                        im  <= bus.wr_data[SR_IM_LO +: 6];
                        exl <= bus.wr_data[SR_EXL];
                        ie  <= bus.wr_data[SR_IE];
                    end
                    CP0_EPC: epc_q <= bus.wr_data & ~32'd3;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Scoreboard bench for cp0_exc_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_cp0_exc_ctrl;

    logic clk;
    logic reset;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl #(
        .PRID       (32'h0000_4D4D),
        .HANDLER_PC (32'h0000_4180)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    localparam int K_RD  = 0;
    localparam int K_REQ = 1;
    localparam int K_EPC = 2;
    localparam int K_HPC = 3;

    exp_t q[$];
    int   total;
    int   bad;

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_RD:    act = bus.rd_data;
                K_REQ:   act = {31'd0, bus.exc_req};
                K_EPC:   act = bus.epc;
                default: act = bus.handler_pc;
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", e.name, act, e.exp);
            end
        end
    end

    task automatic push(input string n, input int k, input logic [31:0] e);
        q.push_back('{name: n, kind: k, exp: e});
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
        bus.rd_addr = a;
        push(n, K_RD, e);
    endtask

    task automatic req(input logic e, input string n);
        push(n, K_REQ, {31'd0, e});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.eret_M = 1'b0;
        bus.exc_code_M = 5'd0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.pc_M = 32'h0;
        bus.exc_code_M = 5'd0;
        bus.bd_M = 1'b0;
        bus.hwint = 6'd0;
        bus.rd_addr = 5'd0;
        bus.wr_addr = 5'd0;
        bus.wr_en = 1'b0;
        bus.wr_data = 32'h0;
        bus.eret_M = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        rd(5'd12, 32'h0, "rst_sr"); req(1'b0, "rst_req");
        push("rst_epc", K_EPC, 32'h0);
        push("hpc", K_HPC, 32'h0000_4180);
        cyc();
        rd(5'd13, 32'h0, "rst_cause"); cyc();
        rd(5'd14, 32'h0, "rst_epcreg"); cyc();
        rd(5'd15, 32'h0000_4D4D, "prid"); cyc();
        rd(5'd3, 32'h0, "other_addr"); cyc();

        // enable IM[10] and IE, then take an interrupt
        mtc0(5'd12, 32'h0000_0401); req(1'b0, "mtc0_req"); cyc();
        rd(5'd12, 32'h0000_0401, "sr_written");
        bus.hwint = 6'b000001; bus.pc_M = 32'h3010; bus.bd_M = 1'b0;
        req(1'b1, "int_req"); cyc();
        rd(5'd14, 32'h3010, "int_epc"); req(1'b0, "int_exl_mask");
        push("int_epc_out", K_EPC, 32'h3010); cyc();
        rd(5'd13, 32'h0000_0400, "int_cause"); cyc();
        rd(5'd12, 32'h0000_0403, "int_sr_exl"); cyc();

        // nested exception while EXL=1 is dropped
        bus.exc_code_M = 5'd4; bus.pc_M = 32'h3100;
        req(1'b0, "nest_req"); cyc();
        rd(5'd13, 32'h0000_0400, "nest_cause");
        push("nest_epc", K_EPC, 32'h3010); cyc();

        // eret, then the pending hwint fires again
        bus.eret_M = 1'b1; req(1'b0, "eret_req"); cyc();
        bus.pc_M = 32'h3040; req(1'b1, "pending_req"); cyc();
        rd(5'd14, 32'h3040, "pending_epc"); cyc();
        bus.hwint = 6'd0; bus.eret_M = 1'b1; cyc();
        rd(5'd12, 32'h0000_0401, "eret_sr"); req(1'b0, "idle_req"); cyc();

        // synchronous exception in a delay slot with IE=0
        mtc0(5'd12, 32'h0000_0400); cyc();
        bus.exc_code_M = 5'd12; bus.pc_M = 32'h3024; bus.bd_M = 1'b1;
        req(1'b1, "ov_req"); cyc();
        bus.bd_M = 1'b0;
        rd(5'd14, 32'h3020, "ov_epc"); cyc();
        rd(5'd13, 32'h8000_0030, "ov_cause"); cyc();
        rd(5'd12, 32'h0000_0402, "ov_sr"); cyc();
        bus.eret_M = 1'b1; cyc();

        // interrupt beats RI; same-cycle mtc0 EPC suppressed
        mtc0(5'd12, 32'h0000_0401); cyc();
        bus.hwint = 6'b000001; bus.exc_code_M = 5'd10; bus.pc_M = 32'h3050;
        mtc0(5'd14, 32'hDEAD_0000);
        req(1'b1, "prio_req"); cyc();
        rd(5'd14, 32'h3050, "prio_epc"); cyc();
        rd(5'd13, 32'h0000_0400, "prio_cause"); cyc();
        rd(5'd12, 32'h0000_0403, "prio_sr"); cyc();

        // reset mid-handler
        bus.hwint = 6'd0;
        reset = 1'b1; cyc();
        reset = 1'b0;
        rd(5'd12, 32'h0, "rst2_sr"); push("rst2_epc", K_EPC, 32'h0);
        req(1'b0, "rst2_req"); cyc();

        // EPC write masks low bits; Cause not writable
        mtc0(5'd14, 32'h0000_1237); cyc();
        rd(5'd14, 32'h0000_1234, "epc_wr"); cyc();
        mtc0(5'd13, 32'hFFFF_FFFF); cyc();
        rd(5'd13, 32'h0, "cause_ro"); cyc();

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d left want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
